// File: rtl/noc_pkt_pkg.sv
// Shared NoC test-packet definitions: framing markers, field widths, error codes and sink FSM states.
package noc_pkt_pkg;

   localparam int unsigned MARK_W = 8;
   localparam int unsigned LEN_W  = 8;
   localparam int unsigned ERR_W  = 3;

   localparam logic [MARK_W-1:0] HEAD_H = 8'hA5;
   localparam logic [MARK_W-1:0] HEAD_E = 8'h5A;
   localparam logic [MARK_W-1:0] TAIL_H = 8'hC3;
   localparam logic [MARK_W-1:0] TAIL_E = 8'h3C;

   typedef enum logic [ERR_W-1:0] {
      ERR_NONE  = 3'd0,
      BAD_HDR   = 3'd1,
      BAD_DST   = 3'd2,
      UNEXP_HDR = 3'd3,
      BAD_DATA  = 3'd4,
      BAD_TAIL  = 3'd5,
      LEN_ERR   = 3'd6,
      STRAY     = 3'd7
   } err_code_t;

   typedef enum logic [1:0] {
      WAIT_HDR  = 2'd0,
      DATA      = 2'd1,
      WAIT_TAIL = 2'd2,
      DROP      = 2'd3
   } state_t;

endpackage

// File: rtl/noc_flit_field_decode.sv
// Combinational header/tail field extraction and marker compare; layout is MSB-first:
// start marker, src X, src Y, dst X, dst Y, len, end marker, reserved.
module noc_flit_field_decode
   import noc_pkt_pkg::*;
#(
   parameter int unsigned DATA_W = 64,
   parameter int unsigned ID_X_W = 4,
   parameter int unsigned ID_Y_W = 4
) (
   input  logic [DATA_W-1:0] flit,
   output logic              head_ok_c,
   output logic              tail_ok_c,
   output logic [ID_X_W-1:0] src_x_c,
   output logic [ID_Y_W-1:0] src_y_c,
   output logic [ID_X_W-1:0] dst_x_c,
   output logic [ID_Y_W-1:0] dst_y_c,
   output logic [LEN_W-1:0]  len_c
);

   localparam int unsigned SMARK_LSB = DATA_W - MARK_W;
   localparam int unsigned SRC_X_LSB = SMARK_LSB - ID_X_W;
   localparam int unsigned SRC_Y_LSB = SRC_X_LSB - ID_Y_W;
   localparam int unsigned DST_X_LSB = SRC_Y_LSB - ID_X_W;
   localparam int unsigned DST_Y_LSB = DST_X_LSB - ID_Y_W;
   localparam int unsigned LEN_LSB   = DST_Y_LSB - LEN_W;
   localparam int unsigned EMARK_LSB = LEN_LSB - MARK_W;

   logic [MARK_W-1:0] start_mark_c;
   logic [MARK_W-1:0] end_mark_c;
   logic              unused_c;

   assign start_mark_c = flit[SMARK_LSB +: MARK_W];
   assign end_mark_c   = flit[EMARK_LSB +: MARK_W];
   assign src_x_c      = flit[SRC_X_LSB +: ID_X_W];
   assign src_y_c      = flit[SRC_Y_LSB +: ID_Y_W];
   assign dst_x_c      = flit[DST_X_LSB +: ID_X_W];
   assign dst_y_c      = flit[DST_Y_LSB +: ID_Y_W];
   assign len_c        = flit[LEN_LSB +: LEN_W];

   assign head_ok_c = (start_mark_c == HEAD_H) && (end_mark_c == HEAD_E);
   assign tail_ok_c = (start_mark_c == TAIL_H) && (end_mark_c == TAIL_E);

   // Reserved bits are deliberately ignored.
   assign unused_c = ^flit;

endmodule

// File: rtl/noc_packet_sink_checker.sv
// Receive-side NoC test endpoint: accepts header/data/tail packets, checks framing, destination,
// length and payload, and reports clean-packet completions and error events.
module noc_packet_sink_checker
   import noc_pkt_pkg::*;
#(
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned ID_X_W     = 4,
   parameter int unsigned ID_Y_W     = 4,
   parameter int unsigned MY_X       = 0,
   parameter int unsigned MY_Y       = 0,
   parameter bit          CHECK_DATA = 1'b1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic              noc_clk,
   input  logic              noc_rst_n,
   input  logic              sink_stall,
   input  logic              receive_valid,
   output logic              receive_ready,
   input  logic [DATA_W-1:0] receive_flit,
   input  logic              receive_is_header,
   input  logic              receive_is_tail,
   output logic              pkt_done,
   output logic [ID_X_W-1:0] pkt_src_x,
   output logic [ID_Y_W-1:0] pkt_src_y,
   output logic [CNT_W-1:0]  pkt_cnt,
   output logic              err_valid,
   output logic [ERR_W-1:0]  err_code,
   output logic [CNT_W-1:0]  err_cnt,
   output logic              busy
);

   localparam logic [ID_X_W-1:0] MY_X_ID = ID_X_W'(MY_X);
   localparam logic [ID_Y_W-1:0] MY_Y_ID = ID_Y_W'(MY_Y);

   state_t            state_q, state_d;
   logic [ID_X_W-1:0] src_x_q, src_x_d;
   logic [ID_Y_W-1:0] src_y_q, src_y_d;
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  beat_q, beat_d;
   err_code_t         pend_q, pend_d;

   logic              head_ok_c, tail_ok_c;
   logic [ID_X_W-1:0] src_x_c, dst_x_c;
   logic [ID_Y_W-1:0] src_y_c, dst_y_c;
   logic [LEN_W-1:0]  len_c;

   logic              accept_c;
   logic              done_c;
   err_code_t         hdr_err_c, hdr_code_c, prim_err_c, sec_err_c, emit_c;

   noc_flit_field_decode #(
      .DATA_W (DATA_W),
      .ID_X_W (ID_X_W),
      .ID_Y_W (ID_Y_W)
   ) u_decode (
      .flit      (receive_flit),
      .head_ok_c (head_ok_c),
      .tail_ok_c (tail_ok_c),
      .src_x_c   (src_x_c),
      .src_y_c   (src_y_c),
      .dst_x_c   (dst_x_c),
      .dst_y_c   (dst_y_c),
      .len_c     (len_c)
   );

   assign accept_c = receive_valid && receive_ready;

   // FSM and context registers.
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         state_q <= WAIT_HDR;
         src_x_q <= '0;
         src_y_q <= '0;
         len_q   <= '0;
         beat_q  <= '0;
         pend_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         src_x_q <= src_x_d;
         src_y_q <= src_y_d;
         len_q   <= len_d;
         beat_q  <= beat_d;
         pend_q  <= pend_d;
      end
   end

   // Next state; a header always restarts packet processing whatever the current state.
   always_comb begin
      state_d    = state_q;
      src_x_d    = src_x_q;
      src_y_d    = src_y_q;
      len_d      = len_q;
      beat_d     = beat_q;
      done_c     = 1'b0;
      prim_err_c = ERR_NONE;
      sec_err_c  = ERR_NONE;
      hdr_err_c  = ERR_NONE;
      hdr_code_c = ERR_NONE;

      if (!head_ok_c) begin
         hdr_err_c = BAD_HDR;
      end else if ((dst_x_c != MY_X_ID) || (dst_y_c != MY_Y_ID)) begin
         hdr_err_c = BAD_DST;
      end

      if (hdr_err_c != ERR_NONE) begin
         hdr_code_c = hdr_err_c;
      end else if (receive_is_tail) begin
         hdr_code_c = LEN_ERR;
      end

      if (accept_c) begin
         if (receive_is_header) begin
            if (receive_is_tail) begin
               state_d = WAIT_HDR;
            end else if (hdr_err_c != ERR_NONE) begin
               state_d = DROP;
            end else begin
               state_d = DATA;
            end
            if (hdr_err_c == ERR_NONE) begin
               src_x_d = src_x_c;
               src_y_d = src_y_c;
               len_d   = len_c;
               beat_d  = '0;
            end
            if ((state_q == DATA) || (state_q == WAIT_TAIL)) begin
               prim_err_c = UNEXP_HDR;
               sec_err_c  = hdr_code_c;
            end else begin
               prim_err_c = hdr_code_c;
            end
         end else begin
            case (state_q)
               WAIT_HDR: prim_err_c = STRAY;
               DATA: begin
                  if (receive_is_tail) begin
                     prim_err_c = LEN_ERR;
                     state_d    = WAIT_HDR;
                  end else if (CHECK_DATA && (receive_flit != {DATA_W{1'b1}})) begin
                     prim_err_c = BAD_DATA;
                     state_d    = DROP;
                  end else if (beat_q == len_q) begin
                     state_d = WAIT_TAIL;
                  end else begin
                     beat_d = beat_q + LEN_W'(1);
                  end
               end
               WAIT_TAIL: begin
                  if (!receive_is_tail) begin
                     prim_err_c = LEN_ERR;
                     state_d    = DROP;
                  end else begin
                     state_d = WAIT_HDR;
                     if (tail_ok_c && (src_x_c == src_x_q) && (src_y_c == src_y_q) &&
                         (dst_x_c == MY_X_ID) && (dst_y_c == MY_Y_ID)) begin
                        done_c = 1'b1;
                     end else begin
                        prim_err_c = BAD_TAIL;
                     end
                  end
               end
               default: begin
                  if (receive_is_tail) state_d = WAIT_HDR;
               end
            endcase
         end
      end

      // A deferred header error from last cycle wins the single error slot.
      if (pend_q != ERR_NONE) begin
         emit_c = pend_q;
         pend_d = prim_err_c;
      end else begin
         emit_c = prim_err_c;
         pend_d = sec_err_c;
      end
   end

   // Registered status and counters.
   always_ff @(posedge noc_clk or negedge noc_rst_n) begin
      if (!noc_rst_n) begin
         receive_ready <= 1'b0;
         pkt_done      <= 1'b0;
         pkt_src_x     <= '0;
         pkt_src_y     <= '0;
         pkt_cnt       <= '0;
         err_valid     <= 1'b0;
         err_code      <= '0;
         err_cnt       <= '0;
         busy          <= 1'b0;
      end else begin
         receive_ready <= !sink_stall;
         pkt_done      <= done_c;
         err_valid     <= (emit_c != ERR_NONE);
         busy          <= (state_d != WAIT_HDR);
         if (done_c) begin
            pkt_src_x <= src_x_q;
            pkt_src_y <= src_y_q;
            pkt_cnt   <= pkt_cnt + CNT_W'(1);
         end
         if (emit_c != ERR_NONE) begin
            err_code <= emit_c;
            if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + CNT_W'(1);
         end
      end
   end

endmodule
